// File: rtl/rv_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow on the start edge.
module rv_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] q, rem, dvs, res;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_r;
    logic            neg_q, neg_r;

    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, ovf, special, accept, last;
    logic [XLEN-1:0] special_res, q_fix, r_fix;
    logic [XLEN:0]   shifted, diff;
    logic            ge;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor : divisor;
        div_zero  = (divisor == '0);
        ovf       = is_signed
                  && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  && (divisor == '1);
        special   = div_zero | ovf;
        if (div_zero)
            special_res = op[1] ? dividend : '1;
        else
            special_res = op[1] ? '0 : dividend;
        accept    = start & ~kill & ((state == IDLE) | (state == DONE));
        last      = (cnt == CW'(XLEN-1));
        // One extra bit keeps the shifted partial remainder exact
        shifted   = {rem, q[XLEN-1]};
        diff      = shifted - {1'b0, dvs};
        ge        = ~diff[XLEN];
        q_fix     = neg_q ? -q : q;
        r_fix     = neg_r ? -rem : rem;
    end

    always_comb begin
        state_n = state;
        if (kill) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_n = special ? DONE : CALC;
                CALC: if (last) state_n = FIX;
                FIX:  state_n = DONE;
                DONE: begin
                    if (accept) state_n = special ? DONE : CALC;
                    else        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            op_r  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res   <= '0;
        end else if (!kill) begin
            if (accept) begin
                op_r  <= op;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (special) begin
                    res <= special_res;
                end else begin
                    q   <= a_abs;
                    rem <= '0;
                    dvs <= b_abs;
                    cnt <= '0;
                end
            end else if (state == CALC) begin
                q   <= {q[XLEN-2:0], ge};
                rem <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                res <= op_r[1] ? r_fix : q_fix;
            end
        end
    end

    assign busy   = (state == CALC) | (state == FIX);
    assign done   = (state == DONE);
    assign result = res;

endmodule
